// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S DAC player.
// Stream constants and the player's state encoding.
package aud_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_PAD   = 2'd3
  } state_t;

  localparam int   DEF_WIDTH = 16;
  localparam int   DEF_DEPTH = 4;
  localparam logic LRC_LEFT  = 1'b0;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; pointers wrap naturally because DEPTH is a power of two.
// ready is registered from the next occupancy so it always agrees with level.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + LVL_ONE;
    end else if (!do_push && do_pop) begin
      level_next = level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_next;
      ready <= (level_next < LVL_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/aud_player.sv
// I2S transmitter toward the codec DAC; the codec masters BCLK and DACLRCK.
// Mono samples are duplicated on both channels, MSB first, one BCLK after each LRCK edge.
module aud_player
  import aud_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_bclk,
  input  logic                   i_lrc,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_dacdat,
  output logic                   o_underflow,
  output logic [$clog2(DEPTH):0] o_level,
  output state_t                 o_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MSB = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t state;
  state_t state_next;

  logic bclk_s1, bclk_s2, bclk_s3;
  logic lrc_s1, lrc_s2;
  logic lrc_q;
  logic bclk_rise, bclk_fall;
  logic frame_edge, frame_left;

  logic [WIDTH-1:0] cur_sample, cur_next;
  logic [CW-1:0]    bit_cnt, cnt_next;
  logic             dac_next;
  logic             uf_next;
  logic             start_word;
  logic             pop;

  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_empty;

  sample_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_valid),
    .pop   (pop),
    .wdata (i_data),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .ready (o_ready),
    .level (o_level)
  );

  assign bclk_rise  = bclk_s2 && !bclk_s3;
  assign bclk_fall  = !bclk_s2 && bclk_s3;
  // LRCK is only looked at on BCLK rises, so a frame edge lasts exactly one cycle.
  assign frame_edge = bclk_rise && (lrc_s2 != lrc_q);
  assign frame_left = frame_edge && (lrc_s2 == LRC_LEFT);
  assign o_state    = state;

  always_comb begin
    state_next = state;
    dac_next   = o_dacdat;
    cnt_next   = bit_cnt;
    cur_next   = cur_sample;
    uf_next    = 1'b0;
    pop        = 1'b0;
    start_word = 1'b0;
    if (i_stop) begin
      state_next = S_IDLE;
      dac_next   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dac_next = 1'b0;
          if (i_start) state_next = S_WAIT;
        end
        S_WAIT: begin
          dac_next = 1'b0;
          if (frame_edge) start_word = 1'b1;
        end
        S_SHIFT: begin
          if (frame_edge) begin
            start_word = 1'b1;
          end else if (bclk_fall) begin
            dac_next = cur_sample[bit_cnt];
            if (bit_cnt == '0) state_next = S_PAD;
            else               cnt_next   = bit_cnt - CNT_ONE;
          end
        end
        S_PAD: begin
          if (frame_edge)     start_word = 1'b1;
          else if (bclk_fall) dac_next   = 1'b0;
        end
        default: state_next = S_IDLE;
      endcase
    end
    // Right words replay the sample fetched for the preceding left word.
    if (start_word) begin
      state_next = S_SHIFT;
      cnt_next   = CNT_MSB;
      if (frame_left) begin
        pop      = !fifo_empty;
        cur_next = fifo_empty ? '0 : fifo_rdata;
        uf_next  = fifo_empty;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bclk_s1     <= 1'b0;
      bclk_s2     <= 1'b0;
      bclk_s3     <= 1'b0;
      lrc_s1      <= 1'b0;
      lrc_s2      <= 1'b0;
      lrc_q       <= 1'b0;
      bit_cnt     <= '0;
      cur_sample  <= '0;
      o_dacdat    <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      bclk_s1     <= i_bclk;
      bclk_s2     <= bclk_s1;
      bclk_s3     <= bclk_s2;
      lrc_s1      <= i_lrc;
      lrc_s2      <= lrc_s1;
      if (bclk_rise) lrc_q <= lrc_s2;
      bit_cnt     <= cnt_next;
      cur_sample  <= cur_next;
      o_dacdat    <= dac_next;
      o_underflow <= uf_next;
    end
  end

endmodule

// File: doc/aud_player.md
Name: aud_player

Overview:
- I2S transmitter toward the codec DAC (DACDAT pin); counterpart of the recorder on the ADC side. Codec is bus master and drives BCLK and DACLRCK.
- Accepts 16-bit signed mono samples through a valid/ready handshake into a small FIFO.
- Serialises each sample MSB-first on both left and right channels, in I2S format with a one-BCLK delay after each LRCK edge.

Parameters:
- DEPTH, 4, FIFO depth in samples; power of two, minimum 2.
- WIDTH, 16, sample width in bits.

Ports:
- i_clk  in  1  system clock; must be at least 8x BCLK.
- i_rst  in  1  synchronous reset, active-high.
- i_bclk  in  1  codec BCLK, asynchronous to i_clk.
- i_lrc  in  1  codec DACLRCK, asynchronous; 0 = left, 1 = right.
- i_start  in  1  level; when high in S_IDLE, arms playback.
- i_stop  in  1  pulse or level; aborts playback.
- i_data  in  WIDTH  signed sample.
- i_valid  in  1  i_data valid.
- o_ready  out  1  FIFO not full.
- o_dacdat  out  1  serial data to the codec.
- o_underflow  out  1  one-cycle pulse when a left frame starts with the FIFO empty.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values (applied on the i_rst cycle): o_dacdat=0, o_underflow=0, o_level=0, o_ready=1, FIFO empty, state S_IDLE, all synchroniser flops 0.
- Synchronisation: i_bclk and i_lrc each pass through 2 flops, plus a 3rd flop for edge detection.
  - A rise is flagged when the synced value is 1 and the previous value was 0; a fall is the reverse.
  - An edge is detected 3 i_clk cycles after the pin changes.
- LRC sampling: i_lrc_s is sampled at each BCLK rise into lrc_q.
  - A change of lrc_q is a frame edge: 1->0 starts a left word, 0->1 starts a right word.
- FSM states:
  - S_IDLE: o_dacdat=0. If i_start=1, go to S_WAIT.
  - S_WAIT: hold 0 until the first frame edge, so playback never starts mid-word.
  - S_SHIFT on a left frame edge:
    - Pop the FIFO into cur_sample; if the FIFO is empty, cur_sample=0 and o_underflow pulses for 1 cycle.
    - bit_cnt=WIDTH-1.
  - S_SHIFT on a right frame edge: reuse cur_sample (mono duplicated).
  - S_SHIFT output: at each BCLK fall after the frame edge, o_dacdat=cur_sample[bit_cnt] and bit_cnt decrements. This gives the I2S 1-BCLK delay (the MSB goes out on the first fall after the edge).
  - S_SHIFT exit: after bit 0 has been driven, go to S_PAD.
  - S_PAD: at each BCLK fall o_dacdat=0. On the next frame edge, return to the S_SHIFT entry behaviour.
  - Short frame: a frame edge arriving while still in S_SHIFT (fewer than WIDTH BCLKs) abandons the current word and starts the new channel word.
- i_stop=1 in any state: next cycle the state is S_IDLE and o_dacdat=0. FIFO contents are preserved. i_stop has priority over i_start in the same cycle.
- FIFO:
  - Push when i_valid && o_ready. o_ready=(o_level<DEPTH), registered from occupancy.
  - Pop only at a left frame edge in S_SHIFT/S_PAD/S_WAIT->S_SHIFT entry.
  - Push and pop in the same cycle: both occur and the level is unchanged. When empty, the pop sees empty (underflow, sample 0) and the pushed word is stored.
  - When full, o_ready=0 and any i_valid is ignored; no overwrite.
  - Pointers wrap modulo DEPTH.
- Arithmetic: sample bits are transmitted raw, two's complement, with no scaling.
- o_dacdat is registered and changes only on detected BCLK falls, so it is stable across the following BCLK rise.

Decomposition:
- Shared package aud_pkg:
  - state enum {S_IDLE, S_WAIT, S_SHIFT, S_PAD}
  - WIDTH default constant
  - LRC_LEFT=1'b0
- One sub-module, sample_fifo: synchronous FIFO with DEPTH/WIDTH parameters, push/pop/level, same clock and reset.
- Edge detection and the FSM stay in aud_player.

Test Plan:
- Reset mid-word: assert i_rst while shifting 16'hA5A5 -> next cycle o_dacdat=0, o_level=0, o_ready=1, state S_IDLE; no underflow pulse.
- Basic frame: push 16'h8001, i_start=1, BCLK=1.536 MHz, i_clk=50 MHz, LRC falls -> first BCLK fall drives 1, next 14 falls drive 0, 16th fall drives 1, then zeros. The right word repeats 8001.
- Ordering: push 16'h1234, 16'hFFFF, 16'h0000, 16'h7FFF -> o_level=4, o_ready=0. A 5th push is ignored. Left words are serialised in push order, and o_level decrements once per left edge.
- Underflow: empty FIFO at a left edge -> o_underflow high exactly 1 cycle, 16 zero bits. A push in the same cycle sets o_level=1, and that sample plays on the next left edge.
- Start alignment: i_start asserted mid-right-word -> o_dacdat stays 0 until the next frame edge, then a full word is sent.
- Stop/short frame: i_stop during bit 7 -> o_dacdat=0 next cycle and o_level unchanged. Separately, an LRC edge after 10 BCLKs restarts at the MSB of the new word.
